// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART <-> crypter word bridge.
package uart_bridge_pkg;

    // Transmit sequencer states.
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_e;

    localparam int DEFAULT_WORD_BYTES = 4;

    // Bits needed to count 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/word_tx_serializer.sv
// Latches one word and feeds it MSB-first, byte by byte, into the UART transmitter.
module word_tx_serializer
    import uart_bridge_pkg::*;
#(
    parameter int WORD_BYTES = DEFAULT_WORD_BYTES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*WORD_BYTES-1:0] word_in,
    input  logic                    word_in_valid,
    output logic                    word_in_ready,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_busy,
    input  logic                    tx_done_tick,
    output logic                    word_sent_tick
);

    localparam int IDX_W = cnt_width(WORD_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    tx_state_e               state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [8*WORD_BYTES-1:0] word_q, word_d;
    logic                    tx_start_q, tx_start_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    sent_q, sent_d;
    logic [7:0]              cur_byte;

    // Byte mux: idx 0 selects the most significant byte of the latched word.
    always_comb begin
        cur_byte = word_q[8*WORD_BYTES-1 -: 8];
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_byte = word_q[8*(WORD_BYTES-1-i) +: 8];
            end
        end
    end

    // Next-state and output logic of the transmit sequencer.
    always_comb begin
        // NOTE: every signal gets a default first, so no branch leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        idx_d      = idx_q;
        word_d     = word_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        sent_d     = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (word_in_valid) begin
                    word_d  = word_in;
                    idx_d   = '0;
                    state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = cur_byte;
                    state_d    = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // tx_busy is deliberately ignored here; only the done tick advances.
                if (tx_done_tick) begin
                    if (idx_q == LAST_IDX) begin
                        sent_d  = 1'b1;
                        state_d = TX_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = TX_SEND;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // State, word latch and registered UART-facing outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= TX_IDLE;
            idx_q      <= '0;
            word_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            sent_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q    <= state_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            sent_q     <= sent_d;
        end
    end

    assign word_in_ready  = (state_q == TX_IDLE);
    assign tx_start       = tx_start_q;
    assign tx_data        = tx_data_q;
    assign word_sent_tick = sent_q;

endmodule

// File: rtl/uart_word_bridge.sv
// Byte/word bridge: packs UART RX bytes into words and serializes words to the UART TX.
module uart_word_bridge
    import uart_bridge_pkg::*;
#(
    parameter int WORD_BYTES = DEFAULT_WORD_BYTES,
    parameter int RX_TIMEOUT = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_readable,
    input  logic [7:0]              rx_data,
    output logic                    rx_used_tick,
    output logic [8*WORD_BYTES-1:0] word_out,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    rx_timeout_tick,
    input  logic [8*WORD_BYTES-1:0] word_in,
    input  logic                    word_in_valid,
    output logic                    word_in_ready,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_busy,
    input  logic                    tx_done_tick,
    output logic                    word_sent_tick
);

    localparam int WORD_BITS = 8 * WORD_BYTES;
    localparam int CNT_W     = cnt_width(WORD_BYTES);
    localparam int TMO_W     = cnt_width(RX_TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(RX_TIMEOUT - 1);

    logic [WORD_BITS-1:0] word_q, word_d;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                 valid_q, valid_d;
    logic                 used_q, used_d;
    logic                 tmo_tick_q, tmo_tick_d;
    logic                 accept;
    logic                 expire;

    // RX packing, word handshake and inter-byte timeout.
    always_comb begin
        // The used-tick term blocks a second read while the UART flag is still clearing.
        accept = rx_readable && !used_q && !valid_q;
        // A byte in the expiry cycle wins over the timeout.
        expire = (RX_TIMEOUT != 0) && !accept && (byte_cnt_q != '0) && (tmo_cnt_q == TMO_LAST);

        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        tmo_cnt_d  = '0;
        valid_d    = valid_q;
        used_d     = accept;
        tmo_tick_d = expire;

        if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            word_d = {word_q[WORD_BITS-9:0], rx_data};
            if (byte_cnt_q == LAST_BYTE) begin
                byte_cnt_d = '0;
                valid_d    = 1'b1;
            end else begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
        end else if (expire) begin
            byte_cnt_d = '0;
        end else if (byte_cnt_q != '0) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    // RX-side registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            valid_q    <= 1'b0;
            used_q     <= 1'b0;
            tmo_tick_q <= 1'b0;
        end else begin
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            valid_q    <= valid_d;
            used_q     <= used_d;
            tmo_tick_q <= tmo_tick_d;
        end
    end

    assign rx_used_tick    = used_q;
    assign word_out        = word_q;
    assign word_valid      = valid_q;
    assign rx_timeout_tick = tmo_tick_q;

    word_tx_serializer #(
        .WORD_BYTES(WORD_BYTES)
    ) u_tx (
        .clk           (clk),
        .rst           (rst),
        .word_in       (word_in),
        .word_in_valid (word_in_valid),
        .word_in_ready (word_in_ready),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_busy       (tx_busy),
        .tx_done_tick  (tx_done_tick),
        .word_sent_tick(word_sent_tick)
    );

endmodule

// File: tb/tb_uart_word_bridge.sv
// Self-checking bench for uart_word_bridge: behavioural model compared every cycle,
// plus directed scenarios with hand-computed expectations and a randomized phase.
module tb_uart_word_bridge;

    localparam int WB = 4;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_readable;
    logic [7:0]  rx_data;
    logic        rx_used_tick;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic        rx_timeout_tick;
    logic [31:0] word_in = 32'h0;
    logic        word_in_valid = 1'b0;
    logic        word_in_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done_tick;
    logic        word_sent_tick;

    uart_word_bridge #(.WORD_BYTES(WB), .RX_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .rx_readable(rx_readable), .rx_data(rx_data), .rx_used_tick(rx_used_tick),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .rx_timeout_tick(rx_timeout_tick),
        .word_in(word_in), .word_in_valid(word_in_valid), .word_in_ready(word_in_ready),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .tx_done_tick(tx_done_tick), .word_sent_tick(word_sent_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- UART RX buffer model (feeds bytes with optional gaps) -------------
    typedef struct { logic [7:0] b; int gap; } rx_item_t;
    rx_item_t rx_feed[$];

    task automatic push_rx(input logic [7:0] b, input int gap);
        rx_item_t e;
        e.b = b; e.gap = gap;
        rx_feed.push_back(e);
    endtask

    initial begin
        rx_item_t e;
        rx_readable = 1'b0;
        rx_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                rx_readable = 1'b0;
            end else begin
                if (rx_used_tick && rx_readable) begin
                    rx_readable = 1'b0;
                    if (rx_feed.size() > 0) void'(rx_feed.pop_front());
                end
                if (!rx_readable && rx_feed.size() > 0) begin
                    e = rx_feed[0];
                    if (e.gap > 0) begin
                        e.gap--;
                        rx_feed[0] = e;
                    end else begin
                        rx_data = e.b;
                        rx_readable = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- UART TX model: done tick tx_lat cycles after tx_start -------------
    int   tx_lat = 10;
    int   tx_cnt = 0;
    logic uart_busy = 1'b0;
    logic hold_busy = 1'b0;
    assign tx_busy = uart_busy | hold_busy;

    initial begin
        tx_done_tick = 1'b0;
        forever begin
            @(posedge clk); #1;
            tx_done_tick = 1'b0;
            if (!rst) begin
                tx_cnt = 0;
                uart_busy = 1'b0;
            end else if (tx_start) begin
                tx_cnt = tx_lat;
                uart_busy = 1'b1;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_done_tick = 1'b1;
                    uart_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- Behavioural reference model ----------------
    // RX: count of bytes in the current partial word, idle cycles since the last byte.
    // TX: queue of bytes still to start, plus a flag for a byte on the wire.
    bit          m_used, m_valid, m_tmo, m_ready_in, m_start, m_sent, m_flight;
    logic [31:0] m_word;
    logic [7:0]  m_data;
    int          m_nbytes, m_wait;
    logic [7:0]  m_pend[$];

    task automatic model_reset();
        m_used = 0; m_valid = 0; m_tmo = 0; m_start = 0; m_sent = 0; m_flight = 0;
        m_ready_in = 1; m_word = '0; m_data = '0; m_nbytes = 0; m_wait = 0;
        m_pend.delete();
    endtask

    task automatic model_step();
        bit acc, exp_t;
        acc   = rx_readable && !m_used && !m_valid;
        exp_t = !acc && (m_nbytes > 0) && (m_wait + 1 == TO);
        if (m_valid && word_ready) m_valid = 0;
        if (acc) begin
            m_word = (m_word << 8) | 32'(rx_data);
            m_nbytes++;
            m_wait = 0;
            if (m_nbytes == WB) begin
                m_nbytes = 0;
                m_valid = 1;
            end
        end else if (exp_t) begin
            m_nbytes = 0;
            m_wait = 0;
        end else if (m_nbytes > 0) begin
            m_wait++;
        end
        m_used = acc;
        m_tmo  = exp_t;

        m_start = 0;
        m_sent  = 0;
        if (!m_flight && m_pend.size() == 0) begin
            if (word_in_valid)
                for (int i = WB - 1; i >= 0; i--) m_pend.push_back(word_in[8*i +: 8]);
        end else if (!m_flight) begin
            if (!tx_busy) begin
                m_start = 1;
                m_data = m_pend.pop_front();
                m_flight = 1;
            end
        end else if (tx_done_tick) begin
            m_flight = 0;
            if (m_pend.size() == 0) m_sent = 1;
        end
        m_ready_in = !m_flight && (m_pend.size() == 0);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // ---------------- Compare process and event log ----------------
    logic [31:0] got_words[$];
    logic [7:0]  txlog[$];
    int          start_cyc[$];
    int used_cnt = 0, tmo_cnt = 0, sent_cnt = 0, valid_cycles = 0;
    int last_used_cyc = 0, tmo_cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            check("rx_used_tick",    rx_used_tick,    m_used);
            check("word_valid",      word_valid,      m_valid);
            check("word_out",        word_out,        m_word);
            check("rx_timeout_tick", rx_timeout_tick, m_tmo);
            check("word_in_ready",   word_in_ready,   m_ready_in);
            check("tx_start",        tx_start,        m_start);
            check("tx_data",         tx_data,         m_data);
            check("word_sent_tick",  word_sent_tick,  m_sent);
            if (word_valid) valid_cycles++;
            if (word_valid && word_ready) got_words.push_back(word_out);
            if (rx_used_tick) begin used_cnt++; last_used_cyc = cyc; end
            if (rx_timeout_tick) begin tmo_cnt++; tmo_cyc = cyc; end
            if (tx_start) begin txlog.push_back(tx_data); start_cyc.push_back(cyc); end
            if (word_sent_tick) sent_cnt++;
        end
    end

    function automatic int evt_count(input int which);
        case (which)
            0: return got_words.size();
            1: return used_cnt;
            2: return tmo_cnt;
            3: return sent_cnt;
            4: return txlog.size();
            default: return 0;
        endcase
    endfunction

    task automatic wait_evt(input string name, input int which, input int target, input int budget);
        int k = 0;
        while (evt_count(which) < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, evt_count(which) >= target, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        int k = 0;
        @(posedge clk); #1;
        word_in = w;
        word_in_valid = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (!word_in_ready && k < 3000);
        check("word_in_ready_wait", word_in_ready, 1'b1);
        @(posedge clk); #1;
        word_in_valid = 1'b0;
        word_in = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_word_in_ready"}, word_in_ready, 1'b1);
        check({tag, "_word_valid"},    word_valid,    1'b0);
        check({tag, "_word_out"},      word_out,      32'h0);
        check({tag, "_rx_used"},       rx_used_tick,  1'b0);
        check({tag, "_timeout"},       rx_timeout_tick, 1'b0);
        check({tag, "_tx_start"},      tx_start,      1'b0);
        check({tag, "_tx_data"},       tx_data,       8'h00);
        check({tag, "_word_sent"},     word_sent_tick, 1'b0);
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    int b, r, s, n, nw, rel;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b1;

        // RX pack with word_ready high.
        b = used_cnt; r = valid_cycles;
        push_rx(8'hDE, 0); push_rx(8'hAD, 0); push_rx(8'hBE, 0); push_rx(8'hEF, 0);
        wait_evt("pack_word", 0, 1, 100);
        check("pack_value", got_words[0], 32'hDEADBEEF);
        repeat (5) @(negedge clk);
        check("pack_used_pulses", used_cnt - b, 4);
        check("pack_valid_one_cycle", valid_cycles - r, 1);

        // Backpressure.
        @(posedge clk); #1 word_ready = 1'b0;
        b = used_cnt; nw = got_words.size();
        push_rx(8'h11, 0); push_rx(8'h22, 0); push_rx(8'h33, 0); push_rx(8'h44, 0);
        wait_evt("bp_packed", 1, b + 4, 100);
        push_rx(8'h55, 0);
        repeat (20) @(negedge clk);
        check("bp_valid_held", word_valid, 1'b1);
        check("bp_word_held", word_out, 32'h11223344);
        check("bp_no_used_for_55", used_cnt - b, 4);
        @(posedge clk); #1 word_ready = 1'b1; r = cyc;
        wait_evt("bp_55_used", 1, b + 5, 20);
        check("bp_55_latency", last_used_cyc - r, 2);
        check("bp_word_taken", got_words[nw], 32'h11223344);
        n = tmo_cnt;
        wait_evt("bp_partial_timeout", 2, n + 1, 300);

        // Timeout after two bytes, then a clean word.
        n = tmo_cnt; nw = got_words.size();
        push_rx(8'h01, 0); push_rx(8'h02, 0);
        wait_evt("to_tick", 2, n + 1, 400);
        check("to_latency", tmo_cyc - last_used_cyc, TO);
        check("to_no_word", got_words.size(), nw);
        push_rx(8'hA0, 0); push_rx(8'hA1, 0); push_rx(8'hA2, 0); push_rx(8'hA3, 0);
        wait_evt("to_next_word", 0, nw + 1, 100);
        check("to_next_value", got_words[nw], 32'hA0A1A2A3);

        // TX serialize with a 10-cycle UART.
        tx_lat = 10; s = txlog.size(); n = sent_cnt;
        send_word(32'hCAFEF00D);
        wait_evt("tx_sent", 3, n + 1, 300);
        check("tx_bytes", {txlog[s], txlog[s+1], txlog[s+2], txlog[s+3]}, 32'hCAFEF00D);
        repeat (5) @(negedge clk);
        check("tx_one_sent", sent_cnt - n, 1);
        check("tx_four_starts", txlog.size() - s, 4);

        // TX holds off while tx_busy is high at word start.
        @(posedge clk); #1 hold_busy = 1'b1;
        s = txlog.size(); n = sent_cnt;
        send_word(32'h12345678);
        repeat (20) @(negedge clk);
        check("busy_no_start", txlog.size() - s, 0);
        @(posedge clk); #1 hold_busy = 1'b0; rel = cyc;
        wait_evt("busy_sent", 3, n + 1, 300);
        check("busy_first_start", start_cyc[s] - rel, 1);
        check("busy_bytes", {txlog[s], txlog[s+1], txlog[s+2], txlog[s+3]}, 32'h12345678);

        // Reset in the middle of an RX word and a TX word.
        s = txlog.size(); b = used_cnt; nw = got_words.size();
        fork
            send_word(32'h0BADF00D);
            begin push_rx(8'h77, 0); push_rx(8'h88, 0); end
        join
        wait_evt("rst_pre_rx", 1, b + 2, 100);
        wait_evt("rst_pre_tx", 4, s + 1, 100);
        @(posedge clk); #1 rst = 1'b0;
        rx_feed.delete();
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1 rst = 1'b1;
        push_rx(8'hC0, 0); push_rx(8'hC1, 0); push_rx(8'hC2, 0); push_rx(8'hC3, 0);
        wait_evt("rst_new_word", 0, nw + 1, 100);
        check("rst_new_value", got_words[nw], 32'hC0C1C2C3);

        // Randomized concurrent RX/TX traffic, checked by the model every cycle.
        n = sent_cnt; nw = got_words.size();
        fork
            begin
                int k = 0;
                for (int i = 0; i < 80; i++) begin
                    int sel = $urandom_range(0, 9);
                    if (sel < 6) push_rx(8'($urandom), 0);
                    else if (sel < 9) push_rx(8'($urandom), $urandom_range(1, 5));
                    else push_rx(8'($urandom), $urandom_range(TO - 5, TO + 5));
                end
                while (rx_feed.size() > 0 && k < 30000) begin
                    @(negedge clk);
                    k++;
                end
                check("rnd_rx_drained", rx_feed.size(), 0);
            end
            begin
                for (int i = 0; i < 15; i++) begin
                    tx_lat = $urandom_range(1, 12);
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    send_word($urandom);
                end
            end
            begin
                for (int i = 0; i < 3000; i++) begin
                    @(posedge clk); #1;
                    word_ready = ($urandom_range(0, 3) != 0);
                    hold_busy  = ($urandom_range(0, 7) == 0);
                end
                @(posedge clk); #1;
                word_ready = 1'b1;
                hold_busy = 1'b0;
            end
        join
        wait_evt("rnd_all_sent", 3, n + 15, 2000);
        repeat (200) @(negedge clk);
        check("rnd_words_seen", got_words.size() > nw, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
